// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
//   Data-memory bus between the MEM-stage controller (master) and the
//   data memory (slave).
//   dmem_req   : request strobe, high for every cycle of an access
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : byte address of the access
//   dmem_wdata : store data
//   dmem_ready : memory has completed the current request
//   dmem_rdata : read data, valid while dmem_ready = 1
interface mem_stage_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   MEM-stage controller for a pipelined CPU with a variable-latency data
//   memory. An aligned load/store in EX/MEM stalls the pipeline while the
//   request is outstanding; a misaligned one is dropped and flagged; a
//   request that is never answered is abandoned after TIMEOUT cycles.
//
//   Ports
//     clk, rst            : clock, asynchronous active-high reset
//     MemRead_in          : load present in EX/MEM
//     MemWrite_in         : store present in EX/MEM (wins over a load)
//     ALUresult_in        : byte address from EX/MEM
//     rt_in               : store data from EX/MEM
//     dmem                : data-memory bus (master side)
//     stall_out           : hold PC, IF/ID, ID/EX and EX/MEM
//     bubble_out          : insert zero control into MEM/WB (= stall_out)
//     rdata_out           : load result presented to MEM/WB
//     misalign_out        : sticky, a misaligned access was seen
//     timeout_out         : sticky, a request was abandoned
//     stall_cnt           : saturating count of stalled cycles
module mem_stage_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MemRead_in,
    input  logic                    MemWrite_in,
    input  logic [31:0]             ALUresult_in,
    input  logic [31:0]             rt_in,
    mem_stage_ctrl_if.master        dmem,
    output logic                    stall_out,
    output logic                    bubble_out,
    output logic [31:0]             rdata_out,
    output logic                    misalign_out,
    output logic                    timeout_out,
    output logic [15:0]             stall_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Wait-counter value seen in the last ACCESS cycle before giving up;
    // the counter starts at 0, so this yields exactly TIMEOUT ACCESS cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,    state_d;
    logic        req_q,      req_d;
    logic        we_q,       we_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q,  timeout_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  wait_q,     wait_d;

    logic op;
    logic aligned;
    logic stall;

    always_comb begin
        op      = MemRead_in | MemWrite_in;
        aligned = (ALUresult_in[1:0] == 2'b00);

        // The IDLE term is combinational so the pipeline freezes in the very
        // cycle the access is detected; rst masks it while reset is held.
        stall = !rst && (((state_q == IDLE) && op && aligned) ||
                         (state_q == ACCESS));

        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        timeout_d   = timeout_q;
        wait_d      = wait_q;

        case (state_q)
            IDLE: begin
                if (op) begin
                    if (aligned) begin
                        state_d = ACCESS;
                        req_d   = 1'b1;
                        we_d    = MemWrite_in;
                        addr_d  = ALUresult_in;
                        wdata_d = rt_in;
                        wait_d  = 8'd0;
                    end else begin
                        misalign_d = 1'b1;
                        rdata_d    = 32'd0;
                    end
                end
            end
            ACCESS: begin
                if (dmem.dmem_ready) begin
                    if (!we_q) begin
                        rdata_d = dmem.dmem_rdata;
                    end
                    state_d = DONE;
                    req_d   = 1'b0;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    rdata_d   = 32'd0;
                    state_d   = DONE;
                    req_d     = 1'b0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE: begin
                // Pipeline advances this cycle; returning to IDLE only now
                // keeps the departing instruction from starting a second access.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
            wait_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            wait_q      <= wait_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign stall_out    = stall;
    assign bubble_out   = stall;
    assign rdata_out    = rdata_q;
    assign misalign_out = misalign_q;
    assign timeout_out  = timeout_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
//   Scoreboard bench for mem_stage_ctrl with TIMEOUT = 4. Each access pushes
//   its expected outcome; the entry is popped and compared in the DONE cycle.
module tb_mem_stage_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [31:0] ALUresult_in;
    logic [31:0] rt_in;
    logic        stall_out;
    logic        bubble_out;
    logic [31:0] rdata_out;
    logic        misalign_out;
    logic        timeout_out;
    logic [15:0] stall_cnt;

    mem_stage_ctrl_if dif ();

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead_in   (MemRead_in),
        .MemWrite_in  (MemWrite_in),
        .ALUresult_in (ALUresult_in),
        .rt_in        (rt_in),
        .dmem         (dif),
        .stall_out    (stall_out),
        .bubble_out   (bubble_out),
        .rdata_out    (rdata_out),
        .misalign_out (misalign_out),
        .timeout_out  (timeout_out),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        tof;
        int          stalls;
        int          scnt;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    logic [31:0] rdata_m = 32'd0;
    logic        to_m    = 1'b0;
    int          scnt_m  = 0;

    // Memory responder: answers in the rdy_delay-th ACCESS cycle (0 = never);
    // outside a request dmem_ready toggles randomly and must be ignored.
    int rdy_delay = 0;
    int acc_cnt   = 0;

    always @(negedge clk) begin
        if (dif.dmem_req) begin
            acc_cnt = acc_cnt + 1;
            dif.dmem_ready = (rdy_delay != 0) && (acc_cnt == rdy_delay);
        end else begin
            acc_cnt = 0;
            dif.dmem_ready = 1'($urandom_range(1, 0));
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mdata,
                          input int delay, input string tag);
        exp_t e;
        exp_t x;
        int   stalls;
        int   accs;
        bit   seen_req;
        bit   done;
        e.we     = wr;
        e.addr   = addr;
        e.wdata  = wdata;
        e.tof    = to_m | (delay == 0 || delay > TO);
        e.stalls = (delay == 0 || delay > TO) ? TO + 1 : delay + 1;
        e.rdata  = wr ? rdata_m : ((delay == 0 || delay > TO) ? 32'd0 : mdata);
        scnt_m   = (scnt_m + e.stalls > 65535) ? 65535 : scnt_m + e.stalls;
        e.scnt   = scnt_m;
        rdata_m  = e.rdata;
        to_m     = e.tof;
        sb.push_back(e);

        rdy_delay      = delay;
        dif.dmem_rdata = mdata;
        MemRead_in     = rd;
        MemWrite_in    = wr;
        ALUresult_in   = addr;
        rt_in          = wdata;

        stalls = 0; accs = 0; seen_req = 0; done = 0;
        for (int cyc = 0; cyc < TO + 10 && !done; cyc++) begin
            @(negedge clk);
            chk({tag, "_bubble"}, 32'(bubble_out), 32'(stall_out));
            if (cyc == 0) begin
                chk({tag, "_idle_req"}, 32'(dif.dmem_req), 32'd0);
                chk({tag, "_idle_stall"}, 32'(stall_out), 32'd1);
            end
            if (stall_out) stalls++;
            if (dif.dmem_req) begin
                seen_req = 1;
                accs++;
                chk({tag, "_addr"}, dif.dmem_addr, sb[0].addr);
                chk({tag, "_we"}, 32'(dif.dmem_we), 32'(sb[0].we));
                chk({tag, "_wdata"}, dif.dmem_wdata, sb[0].wdata);
            end else if (seen_req) begin
                x = sb.pop_front();
                chk({tag, "_done_stall"}, 32'(stall_out), 32'd0);
                chk({tag, "_stalls"}, 32'(stalls), 32'(x.stalls));
                chk({tag, "_accesses"}, 32'(accs), 32'(x.stalls - 1));
                chk({tag, "_rdata"}, rdata_out, x.rdata);
                chk({tag, "_timeout"}, 32'(timeout_out), 32'(x.tof));
                chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(x.scnt));
                done = 1;
            end
        end
        if (!done) begin
            chk({tag, "_no_done"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        MemRead_in     = 1'b1;
        MemWrite_in    = 1'b0;
        ALUresult_in   = 32'h10;
        rt_in          = 32'd0;
        dif.dmem_rdata = 32'd0;

        // Reset state, with an aligned load present to show reset masks stall
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(dif.dmem_req), 32'd0);
        chk("rst_we", 32'(dif.dmem_we), 32'd0);
        chk("rst_addr", dif.dmem_addr, 32'd0);
        chk("rst_wdata", dif.dmem_wdata, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_misalign", 32'(misalign_out), 32'd0);
        chk("rst_timeout", 32'(timeout_out), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_bubble", 32'(bubble_out), 32'd0);
        MemRead_in = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1, "ld_fast");
        run_op(1'b0, 1'b1, 32'h20, 32'h12345678, 32'hBAD0BAD0, 3, "st_slow");
        run_op(1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, 32'h11111111, 2, "rd_wr");

        // Misaligned load: dropped, flagged, result forced to zero
        MemRead_in   = 1'b1;
        ALUresult_in = 32'h13;
        @(negedge clk);
        chk("mis_req", 32'(dif.dmem_req), 32'd0);
        chk("mis_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        chk("mis_flag", 32'(misalign_out), 32'd1);
        chk("mis_rdata", rdata_out, 32'd0);
        chk("mis_req2", 32'(dif.dmem_req), 32'd0);
        chk("mis_stall2", 32'(stall_out), 32'd0);
        MemRead_in = 1'b0;
        rdata_m    = 32'd0;
        @(negedge clk);
        chk("mis_sticky", 32'(misalign_out), 32'd1);
        chk("mis_stall_cnt", 32'(stall_cnt), 32'(scnt_m));
        @(posedge clk);
        #1;

        run_op(1'b1, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, TO, "ld_last_cycle");
        run_op(1'b1, 1'b0, 32'h40, 32'h0, 32'h55555555, 0, "ld_timeout");
        run_op(1'b1, 1'b0, 32'h50, 32'h0, 32'h01020304, 1, "b2b_a");
        run_op(1'b1, 1'b0, 32'h54, 32'h0, 32'h05060708, 2, "b2b_b");

        // Reset pulsed in the second ACCESS cycle of an unanswered load
        rdy_delay    = 0;
        MemRead_in   = 1'b1;
        ALUresult_in = 32'h60;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("ar_req_before", 32'(dif.dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_req", 32'(dif.dmem_req), 32'd0);
        chk("ar_stall", 32'(stall_out), 32'd0);
        chk("ar_bubble", 32'(bubble_out), 32'd0);
        chk("ar_we", 32'(dif.dmem_we), 32'd0);
        chk("ar_addr", dif.dmem_addr, 32'd0);
        chk("ar_rdata", rdata_out, 32'd0);
        chk("ar_misalign", 32'(misalign_out), 32'd0);
        chk("ar_timeout", 32'(timeout_out), 32'd0);
        chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        MemRead_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rdata_m = 32'd0;
        to_m    = 1'b0;
        scnt_m  = 0;
        @(posedge clk);
        #1;

        run_op(1'b1, 1'b0, 32'h70, 32'h0, 32'h0BADCAFE, 2, "ld_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the ACCESS-cycle count after which an unanswered data-memory request is abandoned (legal 1..255).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 MemRead_in  in  1  load present in the EX/MEM register.
REQ-005 MemWrite_in  in  1  store present in the EX/MEM register.
REQ-006 ALUresult_in  in  32  byte address from the EX/MEM register.
REQ-007 rt_in  in  32  store data from the EX/MEM register.
REQ-008 dmem_ready  in  1  data memory has completed the current request.
REQ-009 dmem_rdata  in  32  read data, valid when dmem_ready=1.
REQ-010 dmem_req  out  1  request strobe to data memory.
REQ-011 dmem_we  out  1  1=write, 0=read.
REQ-012 dmem_addr  out  32  latched access address.
REQ-013 dmem_wdata  out  32  latched store data.
REQ-014 stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
REQ-015 bubble_out  out  1  load zero control into MEM/WB.
REQ-016 rdata_out  out  32  load result for MEM/WB.
REQ-017 misalign_out  out  1  sticky flag for a misaligned access.
REQ-018 timeout_out  out  1  sticky flag for an abandoned request.
REQ-019 stall_cnt  out  16  saturating count of cycles with stall_out=1.

Function
REQ-020 The block SHALL use the states IDLE, ACCESS and DONE, one-hot or binary encoded.
REQ-021 Let op=MemRead_in|MemWrite_in and aligned=(ALUresult_in[1:0]==0).
REQ-022 IDLE, op&aligned: stall_out SHALL be 1 combinationally; at the edge, latch addr, wdata and we=MemWrite_in, clear the wait counter, and go to ACCESS.
REQ-023 When MemRead_in and MemWrite_in are both 1, the access SHALL be a write.
REQ-024 IDLE, op&!aligned: no access, no stall; set misalign_out at the edge; rdata_out SHALL be 0 next cycle.
REQ-025 IDLE, !op: stall_out=0; remain in IDLE.
REQ-026 ACCESS: dmem_req=1 and stall_out=1; dmem_addr, dmem_wdata and dmem_we SHALL stay constant.
REQ-027 ACCESS with dmem_ready=1: capture dmem_rdata into rdata_out for reads (rdata_out unchanged for writes); go to DONE.
REQ-028 dmem_ready=1 in the first ACCESS cycle SHALL be accepted.
REQ-029 ACCESS with dmem_ready=0: increment the 8-bit wait counter; when the counter equals TIMEOUT-1, set timeout_out, load rdata_out=0, and go to DONE.
REQ-030 DONE: dmem_req=0 and stall_out=0, so the pipeline advances and MEM/WB captures rdata_out; go unconditionally to IDLE.
REQ-031 The DONE cycle guarantees the same instruction SHALL NOT retrigger an access.
REQ-032 dmem_ready SHALL be ignored in IDLE and DONE.
REQ-033 bubble_out SHALL equal stall_out in every cycle.
REQ-034 Minimum stall SHALL be 2 cycles (IDLE detect + one ACCESS); maximum SHALL be TIMEOUT+1.
REQ-035 stall_cnt SHALL increment on every edge with stall_out=1 and saturate at 0xFFFF.
REQ-036 dmem_addr and dmem_wdata SHALL hold their last latched values outside ACCESS.

Reset
REQ-037 On rst=1, immediately and regardless of clk, the following SHALL be cleared: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, rdata_out=0, misalign_out=0, timeout_out=0, stall_cnt=0, wait counter=0.
REQ-038 While rst=1, stall_out=0 and bubble_out=0.
REQ-039 Reset asserted during ACCESS SHALL abandon the request with no capture; the first edge after release SHALL evaluate IDLE.

Verification
REQ-040 Load at 0x00000010, dmem_ready=1 in the first ACCESS cycle, rdata 0xDEADBEEF -> stall_out high exactly 2 cycles, rdata_out=0xDEADBEEF in DONE, stall_cnt=2.
REQ-041 Store at 0x00000020 with rt_in=0x12345678, dmem_ready after 3 ACCESS cycles -> dmem_we=1 and dmem_wdata=0x12345678 held constant for 3 cycles, 4 stall cycles, rdata_out unchanged.
REQ-042 Load at 0x00000013 -> no dmem_req, stall_out never 1, misalign_out=1 and stays 1, rdata_out=0.
REQ-043 TIMEOUT=4, load with dmem_ready held 0 -> exactly 4 ACCESS cycles, then timeout_out=1, rdata_out=0, return to IDLE via DONE.
REQ-044 rst pulsed in the second ACCESS cycle -> dmem_req and stall_out drop without a clock edge; all outputs reset; the next load proceeds normally.
REQ-045 Back-to-back loads in consecutive instructions -> each gets its own IDLE-ACCESS-DONE sequence, two separate dmem_req bursts, no duplicate access.
